// File: rtl/ycbcr_tile_renderer.sv
// ycbcr_tile_renderer
//   Pulls 4:2:2 YCbCr words from a first-word-fall-through line FIFO inside
//   a programmable active window. It converts them to clamped RGB888 for the
//   HDMI/DVI encoder. Pixels whose tile index differs from the screen tile
//   are blanked, and FIFO underflow is flagged.
//
//   Optional build macro: LINE_CHECK_EN (compare the line number embedded in
//   the first word of each line against the timing generator's line).
//
// Ports
//   i_clk_74M    pixel clock
//   i_rst        asynchronous active-high reset
//   i_hcnt       horizontal timing counter (free running)
//   i_vcnt       vertical timing counter (free running)
//   i_mode       0=YCbCr->RGB, 1=gradient test, 2=luma grey, 3=black
//   i_tile_en    1=blank pixels whose tile index mismatches the screen tile
//   i_fifo_empty FIFO empty
//   i_data       [28:27] tile, [26:16] line, [15:8] Y, [7:0] C (Cr/Cb alternate)
//   o_fifo_read  FIFO pop (combinational)
//   i_clr_err    clears the sticky flags (a coincident set wins)
//   o_r/o_g/o_b  pixel colour, 3 cycles after the input pixel
//   o_de         data enable aligned with o_r/o_g/o_b
//   o_underflow  sticky: FIFO was empty during the active window
//   o_line_err   sticky: line number mismatch (0 unless LINE_CHECK_EN)
module ycbcr_tile_renderer #(
    parameter int HSTART   = 1,
    parameter int HWIDTH   = 1200,
    parameter int VSTART   = 24,
    parameter int VHEIGHT  = 721,
    parameter int TILES_X  = 2,
    parameter int TILE_PIX = 600,
    parameter int CNT_W    = 12
) (
    input  logic             i_clk_74M,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_hcnt,
    input  logic [CNT_W-1:0] i_vcnt,
    input  logic [1:0]       i_mode,
    input  logic             i_tile_en,
    input  logic             i_fifo_empty,
    input  logic [28:0]      i_data,
    output logic             o_fifo_read,
    input  logic             i_clr_err,
    output logic [7:0]       o_r,
    output logic [7:0]       o_g,
    output logic [7:0]       o_b,
    output logic             o_de,
    output logic             o_underflow,
    output logic             o_line_err
);
    typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_HBLANK, S_LINE} state_t;

    localparam int TP_W = (TILE_PIX > 1) ? $clog2(TILE_PIX) : 1;
    localparam logic [CNT_W-1:0] H_BEG   = CNT_W'(HSTART);
    localparam logic [CNT_W-1:0] H_END   = CNT_W'(HSTART + HWIDTH);
    localparam logic [CNT_W-1:0] V_BEG   = CNT_W'(VSTART);
    localparam logic [CNT_W-1:0] V_END   = CNT_W'(VSTART + VHEIGHT);
    localparam logic [TP_W-1:0]  TP_LAST = TP_W'(TILE_PIX - 1);

    state_t          state;
    logic [1:0]      mode_q;
    logic            active, first_px, uf_set;
    logic            px_odd;
    logic [TP_W-1:0] tpix;
    logic [1:0]      tile;
    logic [7:0]      cr_q, cb_q;

    logic [3:1]      vld_pipe;
    logic            blank1, blank2;
    logic [7:0]      y1, y2, hc1, hc2, vc1, vc2;
    logic signed [19:0] ys, crs, cbs;
    logic signed [19:0] r2, g2, b2;
    logic signed [19:0] rs, gs, bs;

    // The window opens on the same cycle the counters reach HSTART and
    // closes on the cycle they reach HSTART+HWIDTH, so it is derived from
    // the current state plus the counters rather than the state alone.
    assign active = (state == S_LINE && i_hcnt != H_END) ||
                    (state == S_HBLANK && i_vcnt != V_END && i_hcnt == H_BEG);
    assign first_px    = active && state != S_LINE;
    assign o_fifo_read = active & ~i_fifo_empty;
    assign uf_set      = active & i_fifo_empty;

    // Frame/line FSM; the mode is latched only on entry to vertical blank.
    always_ff @(posedge i_clk_74M or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_IDLE;
            mode_q <= 2'd0;
        end else begin
            case (state)
                S_IDLE:   if (i_vcnt == '0) begin
                              state  <= S_VBLANK;
                              mode_q <= i_mode;
                          end
                S_VBLANK: if (i_vcnt == V_BEG) state <= S_HBLANK;
                S_HBLANK: if (i_vcnt == V_END) begin
                              state  <= S_VBLANK;
                              mode_q <= i_mode;
                          end else if (i_hcnt == H_BEG) begin
                              state <= S_LINE;
                          end
                S_LINE:   if (i_hcnt == H_END) state <= S_HBLANK;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Column parity and screen tile. Counting pixels within a tile replaces
    // a px / TILE_PIX divider. Everything restarts whenever the window is closed.
    always_ff @(posedge i_clk_74M or posedge i_rst) begin
        if (i_rst) begin
            px_odd <= 1'b0;
            tpix   <= '0;
            tile   <= 2'd0;
        end else if (!active) begin
            px_odd <= 1'b0;
            tpix   <= '0;
            tile   <= 2'd0;
        end else begin
            px_odd <= ~px_odd;
            if (tpix == TP_LAST) begin
                tpix <= '0;
                tile <= tile + 2'd1;
            end else begin
                tpix <= tpix + 1'b1;
            end
        end
    end

    // Stage 1: capture fields. Chroma only updates on a real pop; the pair
    // is cleared between lines so the first pixel sees Cb=0.
    always_ff @(posedge i_clk_74M or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe <= '0;
            y1       <= 8'd0;
            blank1   <= 1'b0;
            hc1      <= 8'd0;
            vc1      <= 8'd0;
            cr_q     <= 8'd0;
            cb_q     <= 8'd0;
        end else begin
            vld_pipe <= {vld_pipe[2:1], active};
            y1       <= i_fifo_empty ? 8'd0 : i_data[15:8];
            blank1   <= i_fifo_empty | (i_tile_en & (i_data[28:27] != tile));
            hc1      <= i_hcnt[9:2];
            vc1      <= i_vcnt[8:1];
            if (!active) begin
                cr_q <= 8'd0;
                cb_q <= 8'd0;
            end else if (!i_fifo_empty) begin
                if (px_odd) cb_q <= i_data[7:0];
                else        cr_q <= i_data[7:0];
            end
        end
    end

    // Stage 2: signed 20-bit products and sums
    assign ys  = {4'd0, y1, 8'd0};
    assign crs = {12'd0, cr_q};
    assign cbs = {12'd0, cb_q};

    always_ff @(posedge i_clk_74M or posedge i_rst) begin
        if (i_rst) begin
            r2     <= '0;
            g2     <= '0;
            b2     <= '0;
            y2     <= 8'd0;
            hc2    <= 8'd0;
            vc2    <= 8'd0;
            blank2 <= 1'b0;
        end else begin
            r2     <= ys + 20'sd359 * crs - 20'sd45952;
            g2     <= ys + 20'sd34688 - 20'sd183 * crs - 20'sd88 * cbs;
            b2     <= ys + 20'sd454 * cbs - 20'sd58112;
            y2     <= y1;
            hc2    <= hc1;
            vc2    <= vc1;
            blank2 <= blank1;
        end
    end

    // Stage 3: arithmetic shift, clamp to 0..255, mode select
    function automatic logic [7:0] clamp8(input logic signed [19:0] v);
        if (v[19])        return 8'd0;
        else if (|v[18:8]) return 8'hff;
        else              return v[7:0];
    endfunction

    assign rs = r2 >>> 8;
    assign gs = g2 >>> 8;
    assign bs = b2 >>> 8;

    always_ff @(posedge i_clk_74M or posedge i_rst) begin
        if (i_rst) begin
            o_r <= 8'd0;
            o_g <= 8'd0;
            o_b <= 8'd0;
        end else if (!vld_pipe[2] || blank2) begin
            o_r <= 8'd0;
            o_g <= 8'd0;
            o_b <= 8'd0;
        end else begin
            case (mode_q)
                2'd0: begin o_r <= clamp8(rs); o_g <= clamp8(gs); o_b <= clamp8(bs); end
                2'd1: begin o_r <= 8'd0;       o_g <= vc2;        o_b <= hc2;        end
                2'd2: begin o_r <= y2;         o_g <= y2;         o_b <= y2;         end
                default: begin o_r <= 8'd0;    o_g <= 8'd0;       o_b <= 8'd0;       end
            endcase
        end
    end

    assign o_de = vld_pipe[3];

    always_ff @(posedge i_clk_74M or posedge i_rst) begin
        if (i_rst)          o_underflow <= 1'b0;
        else if (uf_set)    o_underflow <= 1'b1;
        else if (i_clr_err) o_underflow <= 1'b0;
    end

`ifdef LINE_CHECK_EN
    logic [10:0] vrel;
    logic        le_set;
    logic        line_err_q;

    assign vrel   = 11'(i_vcnt - V_BEG);
    assign le_set = first_px & ~i_fifo_empty & (i_data[26:16] != vrel);

    always_ff @(posedge i_clk_74M or posedge i_rst) begin
        if (i_rst)          line_err_q <= 1'b0;
        else if (le_set)    line_err_q <= 1'b1;
        else if (i_clr_err) line_err_q <= 1'b0;
    end

    assign o_line_err = line_err_q;
`else
    logic unused_line;
    assign unused_line = ^{i_data[26:16], first_px};
    assign o_line_err  = 1'b0;
`endif

endmodule
